crossbar_route_sequencer: RTL and testbench
===========================================

// Module: crossbar_route_sequencer
// PURPOSE
//  Issues control words to a crossbar control port (control/control_val/control_rdy).
//  A host-loaded schedule of route entries {in_sel, out_sel, count} is played out: one control word per entry.
//  Holds each route until `count` payload transfers fire, then advances to the next entry.
//  Sits between the Wishbone-side config logic and one crossbar instance.
// PARAMETERS
//  N_INPUTS           2   crossbar inputs (>=2); IW = $clog2(N_INPUTS)
//  N_OUTPUTS          2   crossbar outputs (>=2); OW = $clog2(N_OUTPUTS)
//  CONTROL_BIT_WIDTH  42  width of the control word; must be >= IW+OW
//  DEPTH              4   schedule entries (power of 2); AW = $clog2(DEPTH)
//  COUNT_WIDTH        16  per-entry transfer count width
// PORTS
//  clk          in   1                  clock
//  reset        in   1                  synchronous, active-high reset
//  cfg_msg      in   AW+IW+OW+COUNT_W   {addr, in_sel, out_sel, count}, MSB first
//  cfg_val      in   1                  cfg write valid
//  cfg_rdy      out  1                  cfg write ready (1 when not busy)
//  start        in   1                  begin schedule at entry 0
//  abort        in   1                  stop schedule, return to IDLE
//  loop_en      in   1                  wrap to entry 0 instead of finishing
//  control      out  CONTROL_BIT_WIDTH  control word to crossbar
//  control_val  out  1                  control word valid
//  control_rdy  in   1                  crossbar accepts control word
//  xfer_fire    in   1                  one payload handshake (val&rdy) on the active route
//  busy         out  1                  state is ISSUE or RUN
//  done         out  1                  one-cycle pulse at schedule completion
//  cur_entry    out  AW                 index of the active entry
// BEHAVIOUR
//  Reset: state = IDLE; table entries = 0; control = 0.
//   Also at reset: control_val = 0, done = 0, busy = 0, cur_entry = 0, xfer counter = 0.
//  Control word layout: control[CBW-1 -: IW] = in_sel; next OW bits = out_sel; remaining LSBs = 0.
//  cfg: write fires on cfg_val & cfg_rdy; table[addr] <= fields at that edge.
//   cfg_rdy = !busy. A cfg_val while busy is not accepted.
//  start is ignored while busy.
//   If start coincides with a cfg write, the write commits first.
//   Entry 0 is then read from the updated table.
//  FSM states: IDLE, ISSUE, RUN, DONE.
//   IDLE, start:
//    - if table[0].count == 0: -> DONE.
//    - else: cur_entry <= 0, -> ISSUE.
//   ISSUE:
//    - control_val = 1; control = word for table[cur_entry], held stable until accepted.
//    - On control_val & control_rdy: -> RUN, counter <= 0.
//   RUN:
//    - control_val = 0, control holds the last word.
//    - Each xfer_fire increments the counter.
//    - The fire that reaches count (counter == count-1) advances: nxt = cur_entry+1 (mod DEPTH).
//    - If nxt == 0 or table[nxt].count == 0: with loop_en (and table[0].count != 0), cur_entry <= 0 -> ISSUE; otherwise -> DONE.
//    - Otherwise: cur_entry <= nxt -> ISSUE.
//    - xfer_fire outside RUN is ignored.
//   DONE: done = 1 for exactly one cycle, then -> IDLE.
//  abort: in any state -> IDLE next edge; control_val drops that edge; counter cleared. No done pulse.
//  Precedence: reset > abort > start / handshake events.
//  The crossbar latches control at the accepting edge, so the route is live in RUN's first cycle.
//  Counter is COUNT_WIDTH bits and does not wrap: it terminates at count-1.
// STRUCTURE
//  Shared package xbar_seq_pkg:
//   - state enum (IDLE / ISSUE / RUN / DONE);
//   - entry struct {in_sel, out_sel, count};
//   - function pack_control(in_sel, out_sel) -> CONTROL_BIT_WIDTH word.
//  Sub-module crossbar_route_table: DEPTH x entry register file.
//   - one synchronous write port, one combinational read port;
//   - reset clears all entries.
//  Top: FSM, xfer counter, control-word mux.
// TESTING
//  1. Reset -> all outputs 0.
//     Write e0={in1,out0,cnt3}, e1={in0,out1,cnt2}, e2 cnt=0.
//     start -> control_val with control[41:40]=2'b10.
//  2. Same schedule, control_rdy stalled 5 cycles:
//     control_val and control stay stable; RUN entered only after rdy.
//     3 fires -> e1 word 2'b01; 2 fires -> done pulse; busy=0.
//  3. loop_en=1, e0 cnt1 only: each fire reissues the e0 word; done never asserts.
//     Then abort -> IDLE next cycle, control_val=0.
//  4. start with table[0].count=0 -> done pulse the following cycle; control_val never asserts.
//  5. cfg_val while busy -> cfg_rdy=0 and the table is unchanged.
//     cfg write coincident with start at addr 0 -> the new e0 route is issued.
//  6. All DEPTH=4 entries nonzero, loop_en=0 -> after e3 completes the schedule ends (done), with no wrap.
//     Reset mid-RUN -> IDLE, and the table is cleared.

Source files
------------

// File: rtl/crossbar_route_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : xbar_seq_pkg
// Description : Shared configuration, types and helpers for the crossbar
//               route sequencer: FSM state enum, schedule entry struct and
//               control-word packing function. Widths are configured here
//               and used by the interface, the route table and the top.
// Revision    : 1.0 - initial release
// ============================================================================
package xbar_seq_pkg;

    localparam int N_INPUTS          = 2;
    localparam int N_OUTPUTS         = 2;
    localparam int CONTROL_BIT_WIDTH = 42;
    localparam int DEPTH             = 4;
    localparam int COUNT_WIDTH       = 16;

    localparam int IW      = $clog2(N_INPUTS);
    localparam int OW      = $clog2(N_OUTPUTS);
    localparam int AW      = $clog2(DEPTH);
    localparam int ENTRY_W = IW + OW + COUNT_WIDTH;
    localparam int MSG_W   = AW + ENTRY_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Field order matches the cfg message layout below the address bits.
    typedef struct packed {
        logic [IW-1:0]          in_sel;
        logic [OW-1:0]          out_sel;
        logic [COUNT_WIDTH-1:0] count;
    } entry_t;

    // in_sel occupies the top IW bits, out_sel the next OW bits, rest zero.
    function automatic logic [CONTROL_BIT_WIDTH-1:0] pack_control(
        input logic [IW-1:0] in_sel,
        input logic [OW-1:0] out_sel
    );
        logic [CONTROL_BIT_WIDTH-1:0] word;
        word = '0;
        word[CONTROL_BIT_WIDTH-1 -: IW]    = in_sel;
        word[CONTROL_BIT_WIDTH-1-IW -: OW] = out_sel;
        return word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/crossbar_route_sequencer_if.sv
`default_nettype none
// ============================================================================
// Interface   : crossbar_route_sequencer_if
// Description : Bundles the schedule configuration write channel
//               (cfg_msg/cfg_val/cfg_rdy) and the crossbar control channel
//               (control/control_val/control_rdy) plus the payload fire
//               strobe of the active route.
//   master : sequencer side (drives cfg_rdy, control, control_val)
//   slave  : host/crossbar side (drives cfg_msg, cfg_val, control_rdy,
//            xfer_fire)
// Revision    : 1.0 - initial release
// ============================================================================
interface crossbar_route_sequencer_if;
    import xbar_seq_pkg::*;

    logic [MSG_W-1:0]             cfg_msg;
    logic                         cfg_val;
    logic                         cfg_rdy;
    logic [CONTROL_BIT_WIDTH-1:0] control;
    logic                         control_val;
    logic                         control_rdy;
    logic                         xfer_fire;

    modport master (
        input  cfg_msg, cfg_val, control_rdy, xfer_fire,
        output cfg_rdy, control, control_val
    );

    modport slave (
        output cfg_msg, cfg_val, control_rdy, xfer_fire,
        input  cfg_rdy, control, control_val
    );

endinterface
`default_nettype wire

// File: rtl/crossbar_route_sequencer_table.sv
`default_nettype none
// ============================================================================
// Module      : crossbar_route_table
// Description : DEPTH x entry_t schedule register file.
//   clk, reset : clock, synchronous active-high reset (clears all entries)
//   we_i       : write enable
//   waddr_i    : write address
//   wdata_i    : write data
//   raddr_i    : combinational read address
//   rdata_o    : combinational read data
// Revision    : 1.0 - initial release
// ============================================================================
module crossbar_route_table
    import xbar_seq_pkg::*;
(
    input  wire          clk,
    input  wire          reset,
    input  wire          we_i,
    input  wire [AW-1:0] waddr_i,
    input  wire entry_t  wdata_i,
    input  wire [AW-1:0] raddr_i,
    output entry_t       rdata_o
);

    entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/crossbar_route_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : crossbar_route_sequencer
// Description : Plays a host-loaded schedule of routes {in_sel, out_sel,
//               count} into a crossbar control port. Each route is issued
//               once and held until `count` payload transfers have fired.
//   clk, reset  : clock, synchronous active-high reset
//   bus         : cfg write channel + crossbar control channel (master)
//   start_i     : begin schedule at entry 0 (ignored while busy)
//   abort_i     : return to IDLE, no done pulse
//   loop_en_i   : wrap to entry 0 instead of finishing
//   busy_o      : ISSUE or RUN
//   done_o      : one-cycle completion pulse
//   cur_entry_o : index of the active entry
// Revision    : 1.0 - initial release
// ============================================================================
module crossbar_route_sequencer
    import xbar_seq_pkg::*;
(
    input  wire                        clk,
    input  wire                        reset,
    crossbar_route_sequencer_if.master bus,
    input  wire                        start_i,
    input  wire                        abort_i,
    input  wire                        loop_en_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [AW-1:0]              cur_entry_o
);

    state_t                 state_q, state_d;
    logic [AW-1:0]          cur_q,   cur_d;
    logic [COUNT_WIDTH-1:0] cnt_q,   cnt_d;
    entry_t                 act_q,   act_d;   // route being issued / live
    entry_t                 e0_q,    e0_d;    // entry 0, reused on wrap

    logic          w_cfg_fire;
    logic [AW-1:0] w_cfg_addr;
    entry_t        w_cfg_entry;
    logic [AW-1:0] w_nxt;
    logic [AW-1:0] w_rd_addr;
    entry_t        w_rd_entry;
    entry_t        w_e0_now;
    logic          w_last_fire;

    assign busy_o      = (state_q == ST_ISSUE) || (state_q == ST_RUN);
    assign done_o      = (state_q == ST_DONE);
    assign cur_entry_o = cur_q;

    assign bus.cfg_rdy     = !busy_o;
    assign bus.control_val = (state_q == ST_ISSUE);
    assign bus.control     = pack_control(act_q.in_sel, act_q.out_sel);

    assign w_cfg_fire  = bus.cfg_val & bus.cfg_rdy;
    assign w_cfg_addr  = bus.cfg_msg[MSG_W-1 -: AW];
    assign w_cfg_entry = entry_t'(bus.cfg_msg[ENTRY_W-1:0]);

    // Single read port: entry 0 while idle (start), the successor in RUN.
    assign w_nxt     = cur_q + AW'(1);
    assign w_rd_addr = (state_q == ST_RUN) ? w_nxt : '0;

    // A cfg write to entry 0 on the start edge must be seen by that start.
    assign w_e0_now = (w_cfg_fire && (w_cfg_addr == '0)) ? w_cfg_entry : w_rd_entry;

    assign w_last_fire = bus.xfer_fire && (cnt_q == act_q.count - COUNT_WIDTH'(1));

    crossbar_route_table u_table (
        .clk     (clk),
        .reset   (reset),
        .we_i    (w_cfg_fire),
        .waddr_i (w_cfg_addr),
        .wdata_i (w_cfg_entry),
        .raddr_i (w_rd_addr),
        .rdata_o (w_rd_entry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            cnt_q   <= '0;
            act_q   <= '0;
            e0_q    <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            e0_q    <= e0_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        act_d   = act_q;
        e0_d    = e0_q;

        if (abort_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        if (w_e0_now.count == '0) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_ISSUE;
                            cur_d   = '0;
                            act_d   = w_e0_now;
                            e0_d    = w_e0_now;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (bus.control_rdy) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end
                end
                ST_RUN: begin
                    if (w_last_fire) begin
                        cnt_d = '0;
                        // Entry 0 is known nonzero here: start required it
                        // and the table cannot change while busy.
                        if ((w_nxt == '0) || (w_rd_entry.count == '0)) begin
                            if (loop_en_i) begin
                                state_d = ST_ISSUE;
                                cur_d   = '0;
                                act_d   = e0_q;
                            end else begin
                                state_d = ST_DONE;
                            end
                        end else begin
                            state_d = ST_ISSUE;
                            cur_d   = w_nxt;
                            act_d   = w_rd_entry;
                        end
                    end else if (bus.xfer_fire) begin
                        cnt_d = cnt_q + COUNT_WIDTH'(1);
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_crossbar_route_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_crossbar_route_sequencer
// Description : Self-checking bench for crossbar_route_sequencer. A small
//               schedule model (arrays of entries) predicts the sequence of
//               routes, their control words and the completion behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crossbar_route_sequencer;
    import xbar_seq_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic          loop_en;
    logic          busy;
    logic          done;
    logic [AW-1:0] cur_entry;

    int n_chk  = 0;
    int n_fail = 0;

    int m_in  [DEPTH];
    int m_out [DEPTH];
    int m_cnt [DEPTH];
    int exp_q [$];

    crossbar_route_sequencer_if bus ();

    crossbar_route_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .start_i     (start),
        .abort_i     (abort),
        .loop_en_i   (loop_en),
        .busy_o      (busy),
        .done_o      (done),
        .cur_entry_o (cur_entry)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CONTROL_BIT_WIDTH-1:0] exp_word(input int e);
        return (CONTROL_BIT_WIDTH'(m_in[e])  << (CONTROL_BIT_WIDTH - IW)) |
               (CONTROL_BIT_WIDTH'(m_out[e]) << (CONTROL_BIT_WIDTH - IW - OW));
    endfunction

    // Route order as the schedule rules describe it.
    function automatic void build_sched(input bit lp, input int maxr);
        int e;
        int n;
        exp_q.delete();
        if (m_cnt[0] == 0) return;
        e = 0;
        while (exp_q.size() < maxr) begin
            exp_q.push_back(e);
            n = (e + 1) % DEPTH;
            if (n == 0 || m_cnt[n] == 0) begin
                if (!lp) break;
                n = 0;
            end
            e = n;
        end
    endfunction

    task automatic set_cfg(input int a, input int i, input int o, input int c);
        bus.cfg_msg = {AW'(a), IW'(i), OW'(o), COUNT_WIDTH'(c)};
        bus.cfg_val = 1'b1;
        m_in[a]  = i;
        m_out[a] = o;
        m_cnt[a] = c;
    endtask

    task automatic cfg_write(input int a, input int i, input int o, input int c);
        chk("cfg_rdy_idle", bus.cfg_rdy, 1);
        set_cfg(a, i, o, c);
        step();
        bus.cfg_val = 1'b0;
    endtask

    // Entered with the DUT presenting entry e; leaves after its last fire.
    task automatic play_route(input int e, input int stall);
        logic [CONTROL_BIT_WIDTH-1:0] w;
        w = exp_word(e);
        chk("issue_val", bus.control_val, 1);
        chk("issue_word", bus.control, w);
        chk("cur_entry", cur_entry, e);
        for (int s = 0; s < stall; s++) begin
            bus.cfg_val   = 1'b1;
            bus.cfg_msg   = MSG_W'($urandom);
            bus.xfer_fire = 1'($urandom);
            step();
            chk("stall_cfg_rdy", bus.cfg_rdy, 0);
            chk("stall_val", bus.control_val, 1);
            chk("stall_word", bus.control, w);
        end
        bus.cfg_val     = 1'b0;
        bus.xfer_fire   = 1'b0;
        bus.control_rdy = 1'b1;
        step();
        bus.control_rdy = 1'b0;
        chk("run_val", bus.control_val, 0);
        chk("run_busy", busy, 1);
        for (int k = 0; k < m_cnt[e]; k++) begin
            repeat ($urandom_range(0, 2)) begin
                step();
                chk("run_wait_val", bus.control_val, 0);
            end
            bus.xfer_fire = 1'b1;
            step();
            bus.xfer_fire = 1'b0;
        end
    endtask

    task automatic run_schedule(input bit lp, input int maxr, input int stall0);
        build_sched(lp, maxr);
        loop_en = lp;
        start   = 1'b1;
        step();
        start       = 1'b0;
        bus.cfg_val = 1'b0;
        chk("start_busy", busy, exp_q.size() != 0);
        foreach (exp_q[i]) begin
            play_route(exp_q[i], (i == 0) ? stall0 : int'($urandom_range(0, 3)));
        end
        if (lp) begin
            chk("loop_reissue", bus.control_val, 1);
            chk("loop_no_done", done, 0);
            abort = 1'b1;
            step();
            abort = 1'b0;
            chk("abort_val", bus.control_val, 0);
            chk("abort_busy", busy, 0);
            chk("abort_done", done, 0);
            step();
            chk("abort_no_done", done, 0);
        end else begin
            chk("done_pulse", done, 1);
            chk("done_busy", busy, 0);
            chk("done_val", bus.control_val, 0);
            step();
            chk("done_clear", done, 0);
        end
        loop_en = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        start           = 1'b0;
        abort           = 1'b0;
        loop_en         = 1'b0;
        bus.cfg_msg     = '0;
        bus.cfg_val     = 1'b0;
        bus.control_rdy = 1'b0;
        bus.xfer_fire   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            m_in[i] = 0; m_out[i] = 0; m_cnt[i] = 0;
        end
        repeat (3) step();
        chk("rst_control", bus.control, 0);
        chk("rst_control_val", bus.control_val, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cur_entry", cur_entry, 0);
        chk("rst_cfg_rdy", bus.cfg_rdy, 1);
        reset = 1'b0;
        step();

        // Two-route schedule, first acceptance stalled 5 cycles.
        cfg_write(0, 1, 0, 3);
        cfg_write(1, 0, 1, 2);
        cfg_write(2, 0, 0, 0);
        run_schedule(1'b0, 16, 5);

        // Loop on a single one-transfer entry, then abort.
        cfg_write(0, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 1);
        cfg_write(1, 1, 1, 0);
        run_schedule(1'b1, 5, 2);

        // Entry 0 empty: immediate done, no control word.
        cfg_write(0, 1, 1, 0);
        run_schedule(1'b0, 16, 0);

        // cfg write to entry 0 on the start edge is seen by that start.
        set_cfg(0, 1, 1, 2);
        run_schedule(1'b0, 16, 1);

        // Full table, no wrap.
        for (int r = 0; r < 3; r++) begin
            for (int a = 0; a < DEPTH; a++) begin
                cfg_write(a, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                          int'($urandom_range(1, 3)));
            end
            run_schedule(1'b0, 16, int'($urandom_range(0, 4)));
        end

        // Reset in the middle of RUN clears state and table.
        start = 1'b1;
        step();
        start           = 1'b0;
        bus.control_rdy = 1'b1;
        step();
        bus.control_rdy = 1'b0;
        chk("midrun_busy", busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mrst_busy", busy, 0);
        chk("mrst_val", bus.control_val, 0);
        chk("mrst_control", bus.control, 0);
        chk("mrst_cur_entry", cur_entry, 0);
        for (int i = 0; i < DEPTH; i++) begin
            m_in[i] = 0; m_out[i] = 0; m_cnt[i] = 0;
        end
        run_schedule(1'b0, 16, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
